// File: rtl/mips_defs.sv
// Shared MIPS encoding constants used by the issue buffer and the control unit.
package mips_defs;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;

  // Link register written by jal
  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/dual_issue_buffer_if.sv
// Fetch-side push port plus the two issue slots of the dual-issue buffer.
interface dual_issue_buffer_if #(
  parameter int PC_W = 32
);
  logic            in_valid1;
  logic            in_valid2;
  logic [31:0]     in_inst1;
  logic [31:0]     in_inst2;
  logic [PC_W-1:0] in_pc1;
  logic [PC_W-1:0] in_pc2;
  logic            in_ready;
  logic            stall;
  logic            flush;
  logic            out_valid1;
  logic            out_valid2;
  logic [31:0]     out_inst1;
  logic [31:0]     out_inst2;
  logic [PC_W-1:0] out_pc1;
  logic [PC_W-1:0] out_pc2;

  // Buffer side
  modport slave (
    input  in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
    input  stall, flush,
    output in_ready,
    output out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2
  );

  // Fetch / control-unit side
  modport master (
    output in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2,
    output stall, flush,
    input  in_ready,
    input  out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2
  );
endinterface

// File: rtl/pair_hazard_check.sv
// Decides whether two adjacent instructions may issue in the same cycle.
// inst1 is the older one (slot 1); inst2 would go to slot 2.
module pair_hazard_check
  import mips_defs::*;
(
  input  logic [31:0] inst1,
  input  logic [31:0] inst2,
  output logic        can_pair
);

  // Architectural destination, 0 when the instruction writes no register.
  function automatic logic [4:0] dest_of(input logic [31:0] ins);
    logic [4:0] d;
    d = 5'd0;
    case (ins[31:26])
      OP_RTYPE:              d = (ins[5:0] == FUNCT_JR) ? 5'd0 : ins[15:11];
      OP_ADDI, OP_ORI, OP_LW: d = ins[20:16];
      OP_JAL:                d = REG_RA;
      default:               d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic reads_rs(input logic [31:0] ins);
    return (ins[31:26] != OP_J) && (ins[31:26] != OP_JAL);
  endfunction

  function automatic logic reads_rt(input logic [31:0] ins);
    return (ins[31:26] == OP_RTYPE) || (ins[31:26] == OP_SW) ||
           (ins[31:26] == OP_BEQ)   || (ins[31:26] == OP_BNE);
  endfunction

  function automatic logic is_ctrl(input logic [31:0] ins);
    return (ins[31:26] == OP_BEQ) || (ins[31:26] == OP_BNE) ||
           (ins[31:26] == OP_J)   || (ins[31:26] == OP_JAL) ||
           ((ins[31:26] == OP_RTYPE) && (ins[5:0] == FUNCT_JR));
  endfunction

  function automatic logic is_mem(input logic [31:0] ins);
    return (ins[31:26] == OP_LW) || (ins[31:26] == OP_SW);
  endfunction

  logic [4:0] dst1;
  logic [4:0] dst2;
  logic       raw;
  logic       waw;
  logic       both_mem;

  assign dst1     = dest_of(inst1);
  assign dst2     = dest_of(inst2);
  assign raw      = (dst1 != 5'd0) &&
                    ((reads_rs(inst2) && (inst2[25:21] == dst1)) ||
                     (reads_rt(inst2) && (inst2[20:16] == dst1)));
  assign waw      = (dst1 != 5'd0) && (dst1 == dst2);
  assign both_mem = is_mem(inst1) && is_mem(inst2);
  assign can_pair = !(is_ctrl(inst1) || both_mem || raw || waw);

endmodule

// File: rtl/dual_issue_buffer.sv
// Instruction queue between fetch and the dual-issue control unit. Accepts up
// to two instructions per cycle and issues the oldest one or two into
// registered slots, pairing only when the hazard check allows it.
module dual_issue_buffer #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input logic               clk,
  input logic               rst,
  dual_issue_buffer_if.slave bus
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];

  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ov1_q, ov1_d, ov2_q, ov2_d;
  logic [31:0]     oi1_q, oi1_d, oi2_q, oi2_d;
  logic [PC_W-1:0] op1_q, op1_d, op2_q, op2_d;

  logic [AW-1:0]   head_p1, tail_p1;
  logic            push1, push2, take1, take2, can_pair;
  logic [1:0]      n_push, n_pop;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Ready looks only at the registered count, never at this cycle's pop.
  assign bus.in_ready = (count_q <= READY_MAX);

  assign push1 = bus.in_ready && bus.in_valid1 && !bus.flush;
  assign push2 = push1 && bus.in_valid2;
  assign take1 = !bus.stall && !bus.flush && (count_q != '0);
  assign take2 = take1 && (count_q >= CW'(2)) && can_pair;

  assign n_push = {1'b0, push1} + {1'b0, push2};
  assign n_pop  = {1'b0, take1} + {1'b0, take2};

  // Entry at head+1 may be stale when count < 2; take2 masks that case.
  pair_hazard_check u_pair (
    .inst1    (inst_mem[head_q]),
    .inst2    (inst_mem[head_p1]),
    .can_pair (can_pair)
  );

  // Queue storage: up to two writes per cycle at tail and tail+1.
  always_ff @(posedge clk) begin
    if (push1) begin
      inst_mem[tail_q] <= bus.in_inst1;
      pc_mem[tail_q]   <= bus.in_pc1;
    end
    if (push2) begin
      inst_mem[tail_p1] <= bus.in_inst2;
      pc_mem[tail_p1]   <= bus.in_pc2;
    end
  end

  // Next-state: flush clears all, stall freezes slots and head, pushes continue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ov1_d   = ov1_q;
    ov2_d   = ov2_q;
    oi1_d   = oi1_q;
    oi2_d   = oi2_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ov1_d   = 1'b0;
      ov2_d   = 1'b0;
      oi1_d   = '0;
      oi2_d   = '0;
      op1_d   = '0;
      op2_d   = '0;
    end else begin
      count_d = count_q + CW'(n_push) - CW'(n_pop);
      tail_d  = tail_q + AW'(n_push);
      head_d  = head_q + AW'(n_pop);
      if (!bus.stall) begin
        ov1_d = take1;
        oi1_d = take1 ? inst_mem[head_q] : '0;
        op1_d = take1 ? pc_mem[head_q] : '0;
        ov2_d = take2;
        oi2_d = take2 ? inst_mem[head_p1] : '0;
        op2_d = take2 ? pc_mem[head_p1] : '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ov1_q   <= 1'b0;
      ov2_q   <= 1'b0;
      oi1_q   <= '0;
      oi2_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ov1_q   <= ov1_d;
      ov2_q   <= ov2_d;
      oi1_q   <= oi1_d;
      oi2_q   <= oi2_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  assign bus.out_valid1 = ov1_q;
  assign bus.out_valid2 = ov2_q;
  assign bus.out_inst1  = oi1_q;
  assign bus.out_inst2  = oi2_q;
  assign bus.out_pc1    = op1_q;
  assign bus.out_pc2    = op2_q;

endmodule

// File: tb/tb_dual_issue_buffer.sv
// Self-checking bench for dual_issue_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_dual_issue_buffer;

  localparam int DEPTH = 8;

  localparam logic [31:0] ADD_3_1_2  = 32'h00221820;
  localparam logic [31:0] ADDI_5_4_1 = 32'h20850001;
  localparam logic [31:0] ADD_6_5_1  = 32'h00A13020;
  localparam logic [31:0] LW_2_0_1   = 32'h8C220000;
  localparam logic [31:0] SW_4_4_3   = 32'hAC640004;
  localparam logic [31:0] BEQ_1_2_8  = 32'h10220008;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic rst;
  dual_issue_buffer_if #(.PC_W(32)) bus ();

  dual_issue_buffer #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  ent_t        mq[$];
  logic        e_v1, e_v2;
  logic [31:0] e_i1, e_i2, e_p1, e_p2;
  logic [31:0] pc_next = 32'h0000_1000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registers written by an instruction, as a bitmask ($0 never counts).
  function automatic logic [31:0] wr_mask(input logic [31:0] x);
    logic [31:0] m = '0;
    if (x[31:26] == 6'h00 && x[5:0] != 6'h08) m[x[15:11]] = 1'b1;
    else if (x[31:26] == 6'h08 || x[31:26] == 6'h0d || x[31:26] == 6'h23) m[x[20:16]] = 1'b1;
    else if (x[31:26] == 6'h03) m[31] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Registers read by an instruction, as a bitmask.
  function automatic logic [31:0] rd_mask(input logic [31:0] x);
    logic [31:0] m = '0;
    if (x[31:26] != 6'h02 && x[31:26] != 6'h03) m[x[25:21]] = 1'b1;
    if (x[31:26] == 6'h00 || x[31:26] == 6'h2b || x[31:26] == 6'h04 || x[31:26] == 6'h05)
      m[x[20:16]] = 1'b1;
    return m;
  endfunction

  function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
    bit ctrl, mem;
    ctrl = (a[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05}) ||
           (a[31:26] == 6'h00 && a[5:0] == 6'h08);
    mem  = (a[31:26] inside {6'h23, 6'h2b}) && (b[31:26] inside {6'h23, 6'h2b});
    return !(ctrl || mem || ((wr_mask(a) & (rd_mask(b) | wr_mask(b))) != 0));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 11))
      0:       return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1:       return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2:       return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      3:       return {6'h00, rs, 15'd0, 6'h08};
      4:       return {6'h08, rs, rt, 16'h0001};
      5:       return {6'h0d, rs, rt, 16'h00f0};
      6:       return {6'h23, rs, rt, 16'h0004};
      7:       return {6'h2b, rs, rt, 16'h0008};
      8:       return {6'h04, rs, rt, 16'h0003};
      9:       return {6'h05, rs, rt, 16'h0002};
      10:      return {6'h02, 26'h0000010};
      default: return {6'h03, 26'h0000020};
    endcase
  endfunction

  task automatic model_clear();
    e_v1 = 1'b0; e_v2 = 1'b0;
    e_i1 = '0;   e_i2 = '0;
    e_p1 = '0;   e_p2 = '0;
  endtask

  task automatic drive(input bit v1, input bit v2, input logic [31:0] a,
                       input logic [31:0] b, input bit st, input bit fl);
    bus.in_valid1 = v1;
    bus.in_valid2 = v2;
    bus.in_inst1  = a;
    bus.in_inst2  = b;
    bus.in_pc1    = pc_next;
    bus.in_pc2    = pc_next + 32'd4;
    bus.stall     = st;
    bus.flush     = fl;
    pc_next       = pc_next + 32'd8;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".v1"}, bus.out_valid1, e_v1);
    check({tag, ".v2"}, bus.out_valid2, e_v2);
    check({tag, ".i1"}, bus.out_inst1, e_i1);
    check({tag, ".i2"}, bus.out_inst2, e_i2);
    check({tag, ".p1"}, bus.out_pc1, e_p1);
    check({tag, ".p2"}, bus.out_pc2, e_p2);
  endtask

  // One clock: check ready, advance the model across the edge, check slots.
  task automatic cycle(input string tag);
    bit   acc, two;
    int   sz;
    ent_t a, b;
    check({tag, ".ready"}, bus.in_ready, (DEPTH - mq.size()) >= 2);
    acc    = bus.in_valid1 && ((DEPTH - mq.size()) >= 2);
    two    = bus.in_valid2;
    a.inst = bus.in_inst1; a.pc = bus.in_pc1;
    b.inst = bus.in_inst2; b.pc = bus.in_pc2;
    @(posedge clk);
    if (bus.flush) begin
      mq.delete();
      model_clear();
    end else begin
      sz = mq.size();
      if (!bus.stall) begin
        model_clear();
        if (sz >= 1) begin
          e_v1 = 1'b1; e_i1 = mq[0].inst; e_p1 = mq[0].pc;
          if (sz >= 2 && pair_ok(mq[0].inst, mq[1].inst)) begin
            e_v2 = 1'b1; e_i2 = mq[1].inst; e_p2 = mq[1].pc;
            void'(mq.pop_front());
          end
          void'(mq.pop_front());
        end
      end
      if (acc) begin
        mq.push_back(a);
        if (two) mq.push_back(b);
      end
    end
    #1;
    check_outputs(tag);
    $display("cycle %s: v1=%0b i1=%h v2=%0b i2=%h q=%0d", tag,
             bus.out_valid1, bus.out_inst1, bus.out_valid2, bus.out_inst2, mq.size());
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      cycle(tag);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.ready", bus.in_ready, 1'b1);
    rst = 1'b1;

    // Single push: issue two edges later, alone.
    drive(1'b1, 1'b0, ADD_3_1_2, '0, 1'b0, 1'b0);
    cycle("single_push");
    idle("single_issue", 1);
    check("single.inst", bus.out_inst1, ADD_3_1_2);
    idle("single_drain", 1);

    // Legal pair issues together.
    drive(1'b1, 1'b1, ADD_3_1_2, ADDI_5_4_1, 1'b0, 1'b0);
    cycle("pair_push");
    idle("pair_issue", 1);
    check("pair.v2", bus.out_valid2, 1'b1);
    idle("pair_drain", 1);

    // Illegal pairs: RAW, two memory ops, branch in slot 1.
    drive(1'b1, 1'b1, ADDI_5_4_1, ADD_6_5_1, 1'b0, 1'b0);
    cycle("raw_push");
    idle("raw_first", 1);
    check("raw.v2", bus.out_valid2, 1'b0);
    idle("raw_second", 1);
    check("raw.inst", bus.out_inst1, ADD_6_5_1);
    drive(1'b1, 1'b1, LW_2_0_1, SW_4_4_3, 1'b0, 1'b0);
    cycle("mem_push");
    idle("mem_issue", 2);
    drive(1'b1, 1'b1, BEQ_1_2_8, ADDI_5_4_1, 1'b0, 1'b0);
    cycle("br_push");
    idle("br_issue", 3);

    // Fill under stall, try an extra push when full, then drain across the wrap.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, {6'h08, 5'd0, 5'(2*k+1), 16'(2*k+1)},
            {6'h08, 5'd0, 5'(2*k+2), 16'(2*k+2)}, 1'b1, 1'b0);
      cycle("fill");
    end
    check("full.ready", bus.in_ready, 1'b0);
    idle("wrap_drain", 6);

    // Flush with count 5 while pushing and stalled.
    drive(1'b1, 1'b1, ADD_3_1_2, ADDI_5_4_1, 1'b1, 1'b0);
    cycle("fl_fill");
    drive(1'b1, 1'b1, ADD_6_5_1, LW_2_0_1, 1'b1, 1'b0);
    cycle("fl_fill");
    drive(1'b1, 1'b0, SW_4_4_3, '0, 1'b1, 1'b0);
    cycle("fl_fill");
    drive(1'b1, 1'b1, BEQ_1_2_8, ADD_3_1_2, 1'b1, 1'b1);
    cycle("flush");
    drive(1'b1, 1'b0, ADDI_5_4_1, '0, 1'b0, 1'b0);
    cycle("post_flush");
    idle("post_flush_issue", 2);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, rand_inst(), rand_inst(),
            $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
      cycle("rand");
    end
    idle("rand_drain", 6);

    // Asynchronous reset between edges while slots are valid.
    drive(1'b1, 1'b1, ADD_3_1_2, ADDI_5_4_1, 1'b0, 1'b0);
    cycle("ar_push");
    drive(1'b1, 1'b1, LW_2_0_1, SW_4_4_3, 1'b0, 1'b0);
    cycle("ar_valid");
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    mq.delete();
    model_clear();
    check_outputs("async_reset");
    check("async_reset.ready", bus.in_ready, 1'b1);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, ADD_6_5_1, '0, 1'b0, 1'b0);
    cycle("after_reset");
    idle("after_reset_issue", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_buffer.md
# dual_issue_buffer

Instruction queue and pairing stage between instruction fetch and the dual-issue control unit. Fetch pushes up to two 32-bit instructions per cycle. Each cycle the block issues the oldest one or two instructions into registered slot 1 and slot 2. The control unit decodes `opCode`/`funct` from these slots. Slot 2 is filled only when the pair is legal to execute together: no control transfer in slot 1, at most one memory op, and no register dependency.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥4.
- `PC_W`, 32: PC width carried with each instruction.
- `clk`  input  1  clock, all state on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid1`, `in_valid2`  input  1 each  push enables; `in_valid2` is honoured only when `in_valid1` is high.
- `in_inst1`, `in_inst2`  input  32 each  instructions; inst1 is older.
- `in_pc1`, `in_pc2`  input  PC_W each  their PCs.
- `in_ready`  output  1  queue has ≥2 free entries; the push is accepted only when it is high.
- `stall`  input  1  downstream hold.
- `flush`  input  1  discard everything (redirect).
- `out_valid1`, `out_valid2`  output  1 each  slot valid.
- `out_inst1`, `out_inst2`  output  32 each  issued instructions.
- `out_pc1`, `out_pc2`  output  PC_W each  issued PCs.

## Operation
- **Queue:** circular buffer with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Push:**
  - When `in_ready` is high and `in_valid1` is high, write inst1 at tail.
  - If `in_valid2` is also high, write inst2 at tail+1.
  - A push while `in_ready` is low is dropped; fetch must hold it.
- **Issue (when `stall` is low and `flush` is low):**
  - Slot 1 takes the head entry if count ≥1.
  - Slot 2 takes head+1 if count ≥2 and pairing is legal.
  - Pop 0, 1 or 2 entries accordingly.
- **Pairing is illegal if any of the following holds:**
  - Slot 1 is a control transfer: beq 0x04, bne 0x05, j 0x02, jal 0x03, or R-type with funct jr 0x08.
  - Both entries are memory ops: lw 0x23 or sw 0x2b.
  - RAW hazard: slot-1 destination is nonzero and equals a slot-2 source.
  - WAW hazard: both destinations are equal and nonzero.
- **Destination register:**
  - R-type (except jr): rd [15:11].
  - addi 0x08, ori 0x0d, lw: rt [20:16].
  - jal: 31.
  - Otherwise none.
- **Source registers:**
  - rs [25:21] for all opcodes except j and jal.
  - rt [20:16] additionally for R-type, sw, beq and bne.
- **Stall:** output registers and the queue head hold. Pushes are still accepted.
- **Flush:**
  - Has priority over push, issue and stall.
  - Next edge: count=0, head=tail=0, `out_valid1`=`out_valid2`=0.
  - A push in the same cycle is discarded.
- **Empty slots:** an invalid slot drives inst 0x00000000 (NOP) and pc 0.
- **Simultaneous push and pop:** allowed. The new count is count + pushed − popped.

## Timing
- Reset (async assert, sync release):
  - All valids 0; `out_inst*` = 0; `out_pc*` = 0.
  - count=0, head=tail=0.
  - `in_ready` = 1.
- `in_ready` is a combinational function of the registered count: DEPTH − count ≥ 2. It does not depend on the same-cycle pop.
- Latency: an instruction pushed at edge N is eligible for selection in cycle N+1 and appears on the outputs after edge N+1. That gives 2 cycles from push to issue when the queue is empty.
- Throughput: up to 2 instructions per cycle in and out.
- Issue order is strictly in program order. Slot 2 is never filled while slot 1 is empty.

## Structure
- Shared definitions package `mips_defs` holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ORI;
  - funct constants: FUNCT_JR, FUNCT_ADD, FUNCT_SUB, FUNCT_AND;
  - REG_RA = 31.
- These constants are also used by the control unit.
- Sub-module `pair_hazard_check`:
  - purely combinational;
  - inputs: two 32-bit instructions;
  - output: `can_pair`;
  - holds all destination/source decode.

## Test plan
- **Reset, then single push:** push add $3,$1,$2 (0x00221820) alone → `out_valid1`=1 two edges later with inst 0x00221820; `out_valid2`=0; `in_ready` stays 1.
- **Legal pair:** push add $3,$1,$2 and addi $5,$4,1 (0x20850001) → both slots valid in the same cycle; count returns to 0.
- **RAW and illegal pairs:**
  - push addi $5,$4,1 then add $6,$5,$1 → slot 2 empty; add issues alone one cycle later.
  - Repeat with lw/sw pairs and with beq in slot 1: same single issue.
- **Full and wrap:** hold `stall`=1 and push 8 instructions → `in_ready`=0 at count ≥7. Release `stall` → order preserved across the pointer wrap; no drops or duplicates.
- **Flush mid-operation:** with count=5 and a push and `stall` active in the same cycle, assert `flush` → next edge count=0, valids 0, pushed instructions lost. The next push issues normally.
- **Async reset mid-stream:** deassert `rst` between edges while slots are valid → outputs clear immediately without waiting for a clock edge.
